// File: rtl/add_sequencer.sv
// add_sequencer: multi-precision adder controller.
// A single W-bit registered adder stage is stepped over LIMBS limbs,
// least-significant limb first. The carry from each limb feeds the next.
// The result is a (W*LIMBS)-bit sum plus a carry-out.
module add_sequencer #(
    parameter int W     = 32,
    parameter int LIMBS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [W*LIMBS-1:0] a,
    input  logic [W*LIMBS-1:0] b,
    input  logic               c_in,
    output logic               busy,
    output logic               done,
    output logic [W*LIMBS-1:0] sum,
    output logic               c_out
);

    localparam int IDXW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LIMBS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // Latched operands, so the producer may change a/b/c_in after the start edge.
    logic [W*LIMBS-1:0] a_q;
    logic [W*LIMBS-1:0] b_q;
    logic               cin_q;

    // Index of the limb that the adder captures on the next RUN edge.
    logic [IDXW-1:0] idx;

    // Registered adder stage. It holds the sum and carry of the limb captured last.
    logic [W-1:0] add_sum;
    logic         add_carry;

    // Combinational adder inputs for the current limb.
    logic [W-1:0] a_limb;
    logic [W-1:0] b_limb;
    logic         cin_sel;
    logic [W:0]   add_result;

    logic accept;

    assign accept = (state == IDLE) && start;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN for LIMBS edges, then one FLUSH edge.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (idx == LAST_IDX) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Select limb idx of the latched operands, and choose the carry-in for that limb.
    always_comb begin
        a_limb  = '0;
        b_limb  = '0;
        for (int i = 0; i < LIMBS; i++) begin
            if (idx == IDXW'(i)) begin
                a_limb = a_q[i*W +: W];
                b_limb = b_q[i*W +: W];
            end
        end
        cin_sel    = (idx == '0) ? cin_q : add_carry;
        add_result = {1'b0, a_limb} + {1'b0, b_limb} + {{W{1'b0}}, cin_sel};
    end

    // Capture the operands when a start is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            cin_q <= c_in;
        end
    end

    // Limb index: cleared on accept, advanced once per RUN edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (accept) begin
            idx <= '0;
        end else if (state == RUN) begin
            idx <= idx + 1'b1;
        end
    end

    // Adder stage register: captures one limb per RUN edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            add_sum   <= '0;
            add_carry <= 1'b0;
        end else if (state == RUN) begin
            {add_carry, add_sum} <= add_result;
        end
    end

    // Result register: write back the previous limb during RUN, and write the top limb plus carry in FLUSH.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum   <= '0;
            c_out <= 1'b0;
        end else if (state == RUN) begin
            for (int i = 1; i < LIMBS; i++) begin
                if (idx == IDXW'(i)) begin
                    sum[(i-1)*W +: W] <= add_sum;
                end
            end
        end else if (state == FLUSH) begin
            sum[(LIMBS-1)*W +: W] <= add_sum;
            c_out                 <= add_carry;
        end
    end

    // Status flags: busy spans accept to FLUSH, and done pulses for the one cycle after FLUSH.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= (state == FLUSH);
            if (accept) begin
                busy <= 1'b1;
            end else if (state == FLUSH) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: doc/add_sequencer.md
Name: add_sequencer

Overview:
- Multi-precision adder controller. Sequences one internal W-bit registered adder stage over LIMBS limbs, least-significant limb first, to produce a (W*LIMBS)-bit sum with carry-out.
- The adder stage registers {carry, sum} = a + b + carry_in on each clk posedge.
- The carry out of each limb feeds back as carry-in of the next limb.
- Sits between wide-operand producers, e.g. a 128-bit ALU op, and the shared 32-bit add datapath.

Parameters:
- W, 32, limb width in bits (width of the internal adder stage)
- LIMBS, 4, number of limbs; legal range LIMBS >= 1

Ports:
- clk  input  1  clock; all state changes on posedge
- rst  input  1  synchronous reset, active-high
- start  input  1  request new operation; sampled on posedge when not busy
- a  input  W*LIMBS  operand A; limb i = a[i*W +: W]
- b  input  W*LIMBS  operand B
- c_in  input  1  carry into limb 0
- busy  output  1  operation in progress; start ignored while high
- done  output  1  one-cycle pulse: sum and c_out valid
- sum  output  W*LIMBS  result register
- c_out  output  1  carry out of the top limb

Behaviour:
- All outputs registered.
- Reset values: busy=0, done=0, sum=0, c_out=0, state=IDLE, limb index=0, internal adder sum/carry register=0.
- rst has priority over all other inputs on the same edge.
- States:
  - IDLE: start=1 at edge E0 latches a, b and c_in into operand registers, clears the limb index, sets busy=1, and moves to RUN.
  - RUN:
    - Each edge, the adder captures limb idx, then idx increments.
    - The adder carry-in is the latched c_in for idx=0, otherwise the adder's registered carry.
    - From the second RUN edge on, the adder's registered sum (limb idx-1) is written into sum[(idx-1)*W +: W] on the same edge.
    - After the edge capturing limb LIMBS-1, move to FLUSH.
  - FLUSH: one edge. Writes the last limb into sum, writes the adder carry into c_out, sets done=1, busy=0, and returns to IDLE.
- Timing: adder captures limb i at edge E(i+1). Last write is at edge E(LIMBS+1). done is high for exactly the one cycle following E(LIMBS+1), which is LIMBS+1 cycles after the start edge. With LIMBS=4, done follows the 5th edge after E0.
- Throughput: one limb per cycle. The carry path is adder register → mux → adder input, within one cycle.
- Operand isolation: a, b and c_in may change freely after E0. Only the latched copies are used.
- start while busy: ignored, with no effect on the operation in progress. Not queued.
- start during the done cycle: state is IDLE, so it is accepted.
  - done returns to 0.
  - sum stays unchanged through the next edge. Limb 0 is first overwritten at the following edge.
- sum contents:
  - Updated limb-by-limb during an operation.
  - Intermediate values are not guaranteed meaningful.
  - sum and c_out are valid from the done cycle until the second edge after the next accepted start.
  - In IDLE with no start, sum and c_out hold.
- rst mid-operation: aborts the operation. All outputs and state go to reset values. No done pulse for the aborted operation.
- Arithmetic:
  - Unsigned modulo 2^(W*LIMBS).
  - c_out = bit W*LIMBS of a + b + c_in.
  - No overflow flag.
- LIMBS=1: RUN lasts one edge. done follows edge E2.

Test Plan:
1. Reset: rst=1 for 2 cycles with start=1 → busy=0, done=0, sum=0, c_out=0; no operation starts.
2. Limb-wise add, W=32, LIMBS=4: a=128'h00000001_00000002_00000003_00000004, b=128'h00000010_00000020_00000030_00000040, c_in=0 → done in cycle after E5; sum=128'h00000011_00000022_00000033_00000044, c_out=0.
3. Full carry ripple: a=128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, b=0, c_in=1 → sum=0, c_out=1; a=128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, b=1, c_in=0 → sum=128'h00000001_00000000_00000000_00000000, c_out=0.
4. start ignored while busy: start=1 at E0 (case 2 operands), then start=1 at E2 with a=b=all ones → single done pulse after E5, case-2 result; no second done pulse.
5. Reset mid-operation: start at E0, rst=1 at E2 → busy=0, sum=0 from the cycle after E2; no done pulse within 10 following cycles.
6. Back-to-back: start asserted in the done cycle of case 2 with case-3 operands → sum holds the case-2 value through the next edge; the second done follows 5 edges later with the case-3 result.
